video_timing_gen: RTL and testbench

Display timing generator for the HDMI overlay pixel pipeline. It runs entirely in the pixel clock domain and produces signed screen coordinates, sync pulses, data-enable and frame/line start strobes. These outputs drive the pixel source/compositor stage directly; every output describes the same pixel in the same cycle. Blanking occupies negative coordinates and the visible area spans 0..RES-1, so downstream effects can prepare during blanking.

---
 rtl/video_timing_gen.sv | 106 ++++++++++
 tb/tb_video_timing_gen.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator with signed coordinates; optional frame_count via VIDEO_TIMING_FRAME_COUNT_EN
module video_timing_gen #(
   parameter int COORDSPC = 16,
   parameter int H_RES    = 1280,
   parameter int H_FP     = 110,
   parameter int H_SYNC   = 40,
   parameter int H_BP     = 220,
   parameter int V_RES    = 720,
   parameter int V_FP     = 5,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 20,
   parameter int H_POL    = 1,
   parameter int V_POL    = 1
) (
   input  logic                       video_clk_pix,
   input  logic                       video_rst,
   output logic                       hsync,
   output logic                       vsync,
   output logic                       video_enable,
   output logic                       frame_start,
   output logic                       line_start,
   output logic signed [COORDSPC-1:0] sx,
   output logic signed [COORDSPC-1:0] sy
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
   ,
   output logic [15:0]                frame_count
`endif
);

   // Blanking sits at negative coordinates; the visible area starts at 0.
   localparam int H_STA = -(H_FP + H_SYNC + H_BP);
   localparam int V_STA = -(V_FP + V_SYNC + V_BP);

   localparam longint C_MAX = (longint'(1) << (COORDSPC - 1)) - 1;
   localparam longint C_MIN = -(longint'(1) << (COORDSPC - 1));

   localparam logic signed [COORDSPC-1:0] ZERO   = '0;
   localparam logic signed [COORDSPC-1:0] ONE    = COORDSPC'(1);
   localparam logic signed [COORDSPC-1:0] H_STA_C = COORDSPC'(H_STA);
   localparam logic signed [COORDSPC-1:0] V_STA_C = COORDSPC'(V_STA);
   localparam logic signed [COORDSPC-1:0] H_END  = COORDSPC'(H_RES - 1);
   localparam logic signed [COORDSPC-1:0] V_END  = COORDSPC'(V_RES - 1);
   localparam logic signed [COORDSPC-1:0] HS_BEG = COORDSPC'(H_STA + H_FP);
   localparam logic signed [COORDSPC-1:0] HS_END = COORDSPC'(H_STA + H_FP + H_SYNC - 1);
   localparam logic signed [COORDSPC-1:0] VS_BEG = COORDSPC'(V_STA + V_FP);
   localparam logic signed [COORDSPC-1:0] VS_END = COORDSPC'(V_STA + V_FP + V_SYNC - 1);

   localparam logic H_ACT = (H_POL != 0);
   localparam logic V_ACT = (V_POL != 0);

   if (longint'(H_RES - 1) > C_MAX || longint'(H_STA) < C_MIN) begin : g_h_range_err
      $error("video_timing_gen: horizontal range does not fit in COORDSPC");
   end
   if (longint'(V_RES - 1) > C_MAX || longint'(V_STA) < C_MIN) begin : g_v_range_err
      $error("video_timing_gen: vertical range does not fit in COORDSPC");
   end
   if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_porch_err
      $error("video_timing_gen: porch and sync widths must be at least 1");
   end

   logic signed [COORDSPC-1:0] nx;
   logic signed [COORDSPC-1:0] ny;

   // Next raster position: advance along the line, wrap to the next line / next frame.
   always_comb begin
      nx = sx + ONE;
      ny = sy;
      if (sx == H_END) begin
         nx = H_STA_C;
         ny = (sy == V_END) ? V_STA_C : sy + ONE;
      end
   end

   // Register counters and derive every output from the next position so all agree per cycle.
   always_ff @(posedge video_clk_pix or posedge video_rst) begin
      if (video_rst) begin
         sx           <= H_STA_C;
         sy           <= V_STA_C;
         hsync        <= ~H_ACT;
         vsync        <= ~V_ACT;
         video_enable <= 1'b0;
         frame_start  <= 1'b0;
         line_start   <= 1'b0;
      end else begin
         sx           <= nx;
         sy           <= ny;
         hsync        <= (nx >= HS_BEG && nx <= HS_END) ? H_ACT : ~H_ACT;
         vsync        <= (ny >= VS_BEG && ny <= VS_END) ? V_ACT : ~V_ACT;
         video_enable <= (nx >= ZERO) && (ny >= ZERO);
         frame_start  <= (nx == H_STA_C) && (ny == V_STA_C);
         line_start   <= (nx == H_STA_C);
      end
   end

`ifdef VIDEO_TIMING_FRAME_COUNT_EN
   // Frame counter steps on the edge that raises frame_start and holds for the whole frame.
   always_ff @(posedge video_clk_pix or posedge video_rst) begin
      if (video_rst) begin
         frame_count <= 16'd0;
      end else if (nx == H_STA_C && ny == V_STA_C) begin
         frame_count <= frame_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - self-checking bench for video_timing_gen on a small raster
module tb_video_timing_gen;

   localparam int CW = 16;
   localparam int HR = 8;
   localparam int HF = 2;
   localparam int HS = 2;
   localparam int HB = 2;
   localparam int VR = 4;
   localparam int VF = 1;
   localparam int VS = 1;
   localparam int VB = 1;
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
   localparam int HP = 0;
   localparam int VP = 0;
`else
   localparam int HP = 1;
   localparam int VP = 1;
`endif
   localparam int HSTA  = -(HF + HS + HB);
   localparam int VSTA  = -(VF + VS + VB);
   localparam int HTOT  = HR - HSTA;
   localparam int VTOT  = VR - VSTA;
   localparam int FRAME = HTOT * VTOT;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic hsync;
   logic vsync;
   logic video_enable;
   logic frame_start;
   logic line_start;
   logic signed [CW-1:0] sx;
   logic signed [CW-1:0] sy;
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
   logic [15:0] frame_count;
`endif

   video_timing_gen #(
      .COORDSPC(CW), .H_RES(HR), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_RES(VR), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .H_POL(HP), .V_POL(VP)
   ) dut (
      .video_clk_pix(clk),
      .video_rst(rst),
      .hsync(hsync),
      .vsync(vsync),
      .video_enable(video_enable),
      .frame_start(frame_start),
      .line_start(line_start),
      .sx(sx),
      .sy(sy)
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
      ,
      .frame_count(frame_count)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int k = 0;            // clock edges since reset release
   int de_cnt = 0;
   bit de_started = 1'b0;
   bit rec_on = 1'b0;
   int fs_q[$];

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d edge=%0d", tag, obs, exp, k);
      end
   endtask

   // Reference: position within the frame is simply the edge count modulo the frame length.
   task automatic check_all();
      int p;
      int px;
      int py;
      int esx;
      int esy;
      int ehs;
      int evs;
      p   = k % FRAME;
      px  = p % HTOT;
      py  = p / HTOT;
      esx = HSTA + px;
      esy = VSTA + py;
      ehs = (esx >= HSTA + HF && esx < HSTA + HF + HS) ? HP : 1 - HP;
      evs = (esy >= VSTA + VF && esy < VSTA + VF + VS) ? VP : 1 - VP;
      check("sx", sx, esx);
      check("sy", sy, esy);
      check("hsync", hsync, ehs);
      check("vsync", vsync, evs);
      check("video_enable", video_enable, (esx >= 0 && esy >= 0) ? 1 : 0);
      check("line_start", line_start, (k > 0 && px == 0) ? 1 : 0);
      check("frame_start", frame_start, (k > 0 && p == 0) ? 1 : 0);
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
      check("frame_count", frame_count, (k / FRAME) % 65536);
`endif
   endtask

   task automatic step();
      int p;
      @(posedge clk);
      if (!rst) k++;
      @(negedge clk);
      check_all();
      p = k % FRAME;
      if (p == 0) begin
         de_cnt = 0;
         de_started = 1'b1;
      end
      if (video_enable === 1'b1) de_cnt++;
      if (p == FRAME - 1 && de_started) check("de_per_frame", de_cnt, HR * VR);
      if (rec_on && frame_start === 1'b1) fs_q.push_back(k);
   endtask

   task automatic async_reset(input int offset);
      #(offset);
      rst = 1'b1;
      #1;
      k = 0;
      de_started = 1'b0;
      check_all();
   endtask

   initial begin
      int n;
      rst = 1'b1;
      repeat (5) step();

      rst = 1'b0;
      rec_on = 1'b1;
      step();
      check("first_edge_sx", sx, HSTA + 1);
      for (int i = 1; i < 300; i++) step();
      rec_on = 1'b0;
      check("fs_count_300", fs_q.size(), 3);
      if (fs_q.size() == 3) begin
         check("fs_edge_1", fs_q[0], FRAME);
         check("fs_edge_2", fs_q[1], 2 * FRAME);
         check("fs_edge_3", fs_q[2], 3 * FRAME);
      end

      // Directed mid-frame reset at (2, 1).
      for (int i = 0; i < FRAME && (k % FRAME) != (1 - VSTA) * HTOT + (2 - HSTA); i++) step();
      check("pre_rst_sx", sx, 2);
      check("pre_rst_sy", sy, 1);
      async_reset(2);
      repeat (2) step();
      rst = 1'b0;
      fs_q.delete();
      rec_on = 1'b1;
      for (int i = 0; i < FRAME + 2; i++) step();
      rec_on = 1'b0;
      check("fs_after_rst_count", fs_q.size(), 1);
      if (fs_q.size() == 1) check("fs_after_rst_edge", fs_q[0], FRAME);

      // Randomized free-run lengths and reset points.
      for (int r = 0; r < 4; r++) begin
         n = $urandom_range(20, 250);
         repeat (n) step();
         async_reset($urandom_range(1, 3));
         n = $urandom_range(1, 4);
         repeat (n) step();
         rst = 1'b0;
         n = $urandom_range(FRAME, 3 * FRAME);
         repeat (n) step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
